sysid_check_master: RTL and testbench

Avalon-MM read master that interrogates the system ID peripheral's control slave and checks it against build-time expected values. It reads word 0 (system ID) and word 1 (build timestamp), captures both, and reports per-field match, overall pass, or timeout. It sits beside the Nios II system as a hardware self-check, so a host or LED can confirm the loaded image matches the intended build without running software.

---
 rtl/sysid_check_master.sv | 146 ++++++++++++++
 tb/tb_sysid_check_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_master.sv
// sysid_check_master: Avalon-MM read master that fetches the system ID (word 0)
// and build timestamp (word 1), compares them with build-time constants, and
// reports per-field match, overall pass, or a waitrequest timeout.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1454761040,
  parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt, wait_inc;
  logic               auto_pend, auto_pend_nxt;
  logic               tmo_hit;
  logic               avm_read_nxt, avm_address_nxt, busy_nxt;
  logic               done_nxt, id_ok_nxt, ts_ok_nxt, timeout_nxt;
  logic [DATA_W-1:0]  id_value_nxt, ts_value_nxt;

  // Overall verdict derived from registered flags only.
  assign pass = done & id_ok & ts_ok & ~timeout;

  // State and output registers; reset abandons any read in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wait_cnt    <= '0;
      auto_pend   <= AUTO_START;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state_q     <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      auto_pend   <= auto_pend_nxt;
      avm_read    <= avm_read_nxt;
      avm_address <= avm_address_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      id_ok       <= id_ok_nxt;
      ts_ok       <= ts_ok_nxt;
      timeout     <= timeout_nxt;
      id_value    <= id_value_nxt;
      ts_value    <= ts_value_nxt;
    end
  end

  // Next-state, capture and stall-timeout logic.
  always_comb begin
    state_nxt     = state_q;
    wait_cnt_nxt  = wait_cnt;
    auto_pend_nxt = auto_pend;
    done_nxt      = done;
    id_ok_nxt     = id_ok;
    ts_ok_nxt     = ts_ok;
    timeout_nxt   = timeout;
    id_value_nxt  = id_value;
    ts_value_nxt  = ts_value;

    // Saturating stall counter; timeout fires on the cycle it reaches the limit.
    wait_inc = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + CNT_W'(1);
    tmo_hit  = (TIMEOUT_CYCLES != 16'd0) && (wait_inc >= TIMEOUT_CYCLES);

    case (state_q)
      IDLE, DONE: begin
        if (start || (state_q == IDLE && auto_pend)) begin
          state_nxt     = RD_ID;
          auto_pend_nxt = 1'b0;
          done_nxt      = 1'b0;
          id_ok_nxt     = 1'b0;
          ts_ok_nxt     = 1'b0;
          timeout_nxt   = 1'b0;
          wait_cnt_nxt  = '0;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          id_value_nxt = avm_readdata;
          id_ok_nxt    = (avm_readdata == EXPECTED_ID);
          wait_cnt_nxt = '0;
          state_nxt    = RD_TS;
        end else begin
          wait_cnt_nxt = wait_inc;
          if (tmo_hit) begin
            timeout_nxt = 1'b1;
            done_nxt    = 1'b1;
            state_nxt   = DONE;
          end
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          ts_value_nxt = avm_readdata;
          ts_ok_nxt    = (avm_readdata == EXPECTED_TIMESTAMP);
          done_nxt     = 1'b1;
          state_nxt    = DONE;
        end else begin
          wait_cnt_nxt = wait_inc;
          if (tmo_hit) begin
            timeout_nxt = 1'b1;
            done_nxt    = 1'b1;
            state_nxt   = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Bus strobes follow the state being entered, so they stay put during stalls.
    busy_nxt        = (state_nxt == RD_ID) || (state_nxt == RD_TS);
    avm_read_nxt    = busy_nxt;
    avm_address_nxt = (state_nxt == RD_TS);
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed self-checking bench for sysid_check_master with a simple
// zero-latency Avalon responder (programmable stall length / stuck stall).
module tb_sysid_check_master;

  localparam logic [31:0] TS_GOOD = 32'd1454761040;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, pass, timeout;
  logic [31:0] id_value, ts_value;

  int checks = 0;
  int errors = 0;

  // Responder controls
  logic [31:0] id_resp;
  logic [31:0] ts_resp;
  int          stall_n;
  bit          stuck;

  // Monitor state
  int stall_cnt  = 0;
  int rd_count   = 0;
  int rd_cycles  = 0;
  bit prev_stall = 1'b0;
  bit prev_addr  = 1'b0;
  bit stall_viol = 1'b0;

  sysid_check_master #(
    .EXPECTED_ID        (32'd0),
    .EXPECTED_TIMESTAMP (TS_GOOD),
    .TIMEOUT_CYCLES     (16'd4),
    .AUTO_START         (1'b1)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .pass            (pass),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  always #5 clock = ~clock;

  assign avm_waitrequest = avm_read && (stuck || (stall_cnt < stall_n));
  assign avm_readdata    = avm_address ? ts_resp : id_resp;

  // Responder stall counter, transfer counters and stall-stability monitor.
  always @(posedge clock) begin
    stall_cnt  <= (avm_read && avm_waitrequest) ? stall_cnt + 1 : 0;
    if (avm_read && !avm_waitrequest) rd_count <= rd_count + 1;
    if (avm_read) rd_cycles <= rd_cycles + 1;
    prev_stall <= avm_read && avm_waitrequest;
    prev_addr  <= avm_address;
    if (prev_stall && reset_n &&
        ((avm_read && (avm_address != prev_addr)) || (!avm_read && !timeout)))
      stall_viol <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int r0;
    reset_n = 1'b0;
    start   = 1'b0;
    id_resp = 32'd0;
    ts_resp = TS_GOOD;
    stall_n = 0;
    stuck   = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_read", avm_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_id_value", id_value, 0);

    // Auto-start after reset release
    reset_n = 1'b1;
    @(negedge clock);
    chk("auto_busy", busy, 1);
    chk("auto_read", avm_read, 1);
    chk("auto_addr0", avm_address, 0);
    @(negedge clock);
    chk("auto_addr1", avm_address, 1);
    chk("auto_id_ok", id_ok, 1);
    @(negedge clock);
    chk("auto_done", done, 1);
    chk("auto_pass", pass, 1);
    chk("auto_ts_value", ts_value, TS_GOOD);
    chk("auto_read_off", avm_read, 0);
    chk("auto_busy_off", busy, 0);

    // Nominal start
    c0 = rd_cycles;
    pulse_start();
    chk("nom_read", avm_read, 1);
    chk("nom_addr0", avm_address, 0);
    chk("nom_done_clr", done, 0);
    @(negedge clock);
    chk("nom_addr1", avm_address, 1);
    @(negedge clock);
    chk("nom_done", done, 1);
    chk("nom_id_ok", id_ok, 1);
    chk("nom_ts_ok", ts_ok, 1);
    chk("nom_pass", pass, 1);
    chk("nom_ts_value", ts_value, TS_GOOD);
    chk("nom_read_cycles", 32'(rd_cycles - c0), 2);

    // Timestamp mismatch
    ts_resp = TS_GOOD + 32'd1;
    pulse_start();
    repeat (2) @(negedge clock);
    chk("mis_done", done, 1);
    chk("mis_id_ok", id_ok, 1);
    chk("mis_ts_ok", ts_ok, 0);
    chk("mis_pass", pass, 0);
    chk("mis_ts_value", ts_value, TS_GOOD + 32'd1);

    // ID mismatch
    ts_resp = TS_GOOD;
    id_resp = 32'd5;
    pulse_start();
    repeat (2) @(negedge clock);
    chk("idm_id_ok", id_ok, 0);
    chk("idm_ts_ok", ts_ok, 1);
    chk("idm_pass", pass, 0);
    chk("idm_id_value", id_value, 5);
    id_resp = 32'd0;

    // Three wait states per read: done lands 8 cycles after start
    stall_n = 3;
    pulse_start();
    repeat (7) @(negedge clock);
    chk("ws_done_early", done, 0);
    chk("ws_busy", busy, 1);
    chk("ws_addr1", avm_address, 1);
    @(negedge clock);
    chk("ws_done", done, 1);
    chk("ws_pass", pass, 1);
    chk("ws_stable", 32'(stall_viol), 0);
    stall_n = 0;

    // Stuck waitrequest: timeout 4 cycles after start
    stuck = 1'b1;
    pulse_start();
    chk("to_done_clr", done, 0);
    chk("to_busy", busy, 1);
    repeat (3) @(negedge clock);
    chk("to_done_early", done, 0);
    chk("to_busy_early", busy, 1);
    @(negedge clock);
    chk("to_done", done, 1);
    chk("to_timeout", timeout, 1);
    chk("to_pass", pass, 0);
    chk("to_read_off", avm_read, 0);
    chk("to_id_ok", id_ok, 0);
    stuck = 1'b0;
    pulse_start();
    chk("to_clear", timeout, 0);
    repeat (2) @(negedge clock);
    chk("to_recover_pass", pass, 1);
    chk("to_recover_timeout", timeout, 0);

    // Start while busy is ignored
    r0 = rd_count;
    pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("sb_done", done, 1);
    chk("sb_pass", pass, 1);
    repeat (4) @(negedge clock);
    chk("sb_reads", 32'(rd_count - r0), 2);
    chk("sb_busy", busy, 0);
    chk("sb_done_held", done, 1);

    // Reset during timestamp read, then auto-start relaunch
    pulse_start();
    @(negedge clock);
    chk("mr_busy", busy, 1);
    chk("mr_addr1", avm_address, 1);
    reset_n = 1'b0;
    #1;
    chk("mr_read", avm_read, 0);
    chk("mr_addr", avm_address, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_id_ok", id_ok, 0);
    chk("mr_ts_ok", ts_ok, 0);
    chk("mr_timeout", timeout, 0);
    chk("mr_pass", pass, 0);
    chk("mr_id_value", id_value, 0);
    chk("mr_ts_value", ts_value, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("mr_auto_busy", busy, 1);
    repeat (2) @(negedge clock);
    chk("mr_auto_done", done, 1);
    chk("mr_auto_pass", pass, 1);
    chk("final_stable", 32'(stall_viol), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
